// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared states, control encodings and NOP/x0 constants
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [4:0]  REG_X0   = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } ctrl_t;

  // Whole-pipe control patterns, one per priority level
  localparam ctrl_t CTRL_NONE       = 6'b000000;
  localparam ctrl_t CTRL_FREEZE     = 6'b110011;
  localparam ctrl_t CTRL_JUMP       = 6'b001100;
  localparam ctrl_t CTRL_LOAD_USE   = 6'b110100;
  localparam ctrl_t CTRL_FETCH_MISS = 6'b101000;
  localparam ctrl_t CTRL_RESET      = 6'b001100;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline status inputs and stall/flush controls
interface pipe_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_jump_en;
  logic       imem_ready;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_stall;
  logic       mem_wb_flush;

  // master is the datapath reporting status, slave is the controller
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
    output ex_jump_en, imem_ready, mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
    input  ex_jump_en, imem_ready, mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_flush
  );

endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// rtl/pipe_ctrl_hazard_det.sv - combinational load-use hazard compare
module hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_used & (id_rs1 == ex_rd);
  assign rs2_hit  = id_rs2_used & (id_rs2 == ex_rd);
  // x0 is never a real producer, so a load to it cannot create a hazard
  assign load_use = ex_mem_read & (ex_rd != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with data-memory wait FSM
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_ctrl_if.slave       pif,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu_prev;
  logic              load_use;
  logic              hold;
  logic              freeze;
  logic              jump_flush;
  logic              lu_fire;
  ctrl_t             ctrl;

  hazard_det u_hazard_det (
    .id_rs1      (pif.id_rs1),
    .id_rs2      (pif.id_rs2),
    .id_rs1_used (pif.id_rs1_used),
    .id_rs2_used (pif.id_rs2_used),
    .ex_rd       (pif.ex_rd),
    .ex_mem_read (pif.ex_mem_read),
    .load_use    (load_use)
  );

  assign hold       = pif.mem_req & ~pif.mem_ready;
  assign freeze     = (state == HALT) | hold;
  assign jump_flush = ~freeze & pif.ex_jump_en;
  // The bubble just inserted sits in EX next cycle, so a repeat is never a new hazard
  assign lu_fire    = ~freeze & ~pif.ex_jump_en & load_use & ~lu_prev;

  always_comb begin
    ctrl = CTRL_NONE;
    if (!reset)
      ctrl = CTRL_RESET;
    else if (freeze)
      ctrl = CTRL_FREEZE;
    else if (pif.ex_jump_en)
      ctrl = CTRL_JUMP;
    else if (lu_fire)
      ctrl = CTRL_LOAD_USE;
    else if (!pif.imem_ready)
      ctrl = CTRL_FETCH_MISS;
  end

  assign pif.pc_stall     = ctrl.pc_stall;
  assign pif.if_id_stall  = ctrl.if_id_stall;
  assign pif.if_id_flush  = ctrl.if_id_flush;
  assign pif.id_ex_flush  = ctrl.id_ex_flush;
  assign pif.ex_mem_stall = ctrl.ex_mem_stall;
  assign pif.mem_wb_flush = ctrl.mem_wb_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hold) begin
            state    <= DWAIT;
            wait_cnt <= '0;
          end
        end
        DWAIT: begin
          if (pif.mem_ready) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
              state   <= HALT;
              bus_err <= 1'b1;
            end
          end
        end
        HALT: begin
          bus_err <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lu_prev   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      lu_prev <= lu_fire;
      if (ctrl.pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (jump_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       jmp;
    logic       imr;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_flush, bus_err}
  localparam logic [6:0] E_IDLE = 7'b000000_0;
  localparam logic [6:0] E_FRZ  = 7'b110011_0;
  localparam logic [6:0] E_JMP  = 7'b001100_0;
  localparam logic [6:0] E_LU   = 7'b110100_0;
  localparam logic [6:0] E_FM   = 7'b101000_0;
  localparam logic [6:0] E_HLT  = 7'b110011_1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bus_err;
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [6:0] exp_q[$];

  pipe_ctrl_if pif ();

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pif       (pif),
    .bus_err   (bus_err),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input int rs1, input int u1, input int rs2, input int u2,
                               input int rd, input int mr, input int jmp, input int imr,
                               input int mreq, input int mrdy);
    stim_t s;
    s.rs1 = 5'(rs1); s.u1 = 1'(u1); s.rs2 = 5'(rs2); s.u2 = 1'(u2);
    s.rd = 5'(rd); s.mr = 1'(mr); s.jmp = 1'(jmp); s.imr = 1'(imr);
    s.mreq = 1'(mreq); s.mrdy = 1'(mrdy);
    return s;
  endfunction

  function automatic logic [6:0] sample();
    return {pif.pc_stall, pif.if_id_stall, pif.if_id_flush, pif.id_ex_flush,
            pif.ex_mem_stall, pif.mem_wb_flush, bus_err};
  endfunction

  task automatic apply(input stim_t s);
    pif.id_rs1 = s.rs1; pif.id_rs1_used = s.u1;
    pif.id_rs2 = s.rs2; pif.id_rs2_used = s.u2;
    pif.ex_rd = s.rd; pif.ex_mem_read = s.mr; pif.ex_jump_en = s.jmp;
    pif.imem_ready = s.imr; pif.mem_req = s.mreq; pif.mem_ready = s.mrdy;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    logic [6:0] want;
    #1 reset = 1'b0;
    apply(mk(5, 1, 0, 0, 5, 1, 1, 0, 1, 0));
    @(negedge clk);
    got = sample();
    n_cmp++;
    if ({got[6:2], got[0]} !== 6'b00110_0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00110x0", got);
    end
    n_cmp++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    exp_q.push_back(E_IDLE);
    @(negedge clk);
    got = sample();
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL reset_release: got %b want %b", got, want);
    end
  endtask

  task automatic test_load_use();
    stim_t s[$];
    logic [6:0] e[$];
    logic [6:0] got;
    logic [6:0] want;
    do_reset();
    s.push_back(mk(5, 1, 0, 0, 5, 1, 0, 1, 0, 0)); e.push_back(E_LU);
    s.push_back(mk(5, 1, 0, 0, 5, 1, 0, 1, 0, 0)); e.push_back(E_IDLE);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(E_IDLE);
    s.push_back(mk(0, 1, 7, 1, 7, 1, 0, 1, 0, 0)); e.push_back(E_LU);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(E_IDLE);
    s.push_back(mk(9, 1, 0, 0, 9, 1, 0, 0, 0, 0)); e.push_back(E_LU);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_FM);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(E_IDLE);
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got = sample();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL load_use step %0d: got %b want %b", i, got, want);
      end
    end
    n_cmp++;
    if (stall_cnt !== 4'd4) begin
      n_bad++; $display("FAIL load_use stall_cnt: got %0d want 4", stall_cnt);
    end
  endtask

  task automatic test_x0_unused();
    stim_t s[$];
    logic [6:0] e[$];
    logic [6:0] got;
    logic [6:0] want;
    do_reset();
    s.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0)); e.push_back(E_IDLE);
    s.push_back(mk(3, 1, 5, 0, 5, 1, 0, 1, 0, 0)); e.push_back(E_IDLE);
    s.push_back(mk(5, 1, 0, 0, 5, 0, 0, 1, 0, 0)); e.push_back(E_IDLE);
    s.push_back(mk(5, 0, 5, 1, 5, 1, 0, 1, 0, 0)); e.push_back(E_LU);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(E_IDLE);
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got = sample();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL x0_unused step %0d: got %b want %b", i, got, want);
      end
    end
    n_cmp++;
    if (stall_cnt !== 4'd1) begin
      n_bad++; $display("FAIL x0_unused stall_cnt: got %0d want 1", stall_cnt);
    end
  endtask

  task automatic test_jump_fetch_miss();
    stim_t s[$];
    logic [6:0] e[$];
    logic [6:0] got;
    logic [6:0] want;
    do_reset();
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(E_JMP);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_FM);
    s.push_back(mk(4, 1, 0, 0, 4, 1, 1, 1, 0, 0)); e.push_back(E_JMP);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(E_IDLE);
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got = sample();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL jump_fetch_miss step %0d: got %b want %b", i, got, want);
      end
    end
    n_cmp++;
    if (flush_cnt !== 4'd2 || stall_cnt !== 4'd1) begin
      n_bad++; $display("FAIL jump_fetch_miss cnt: got flush %0d stall %0d want 2 1", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_hold_jump();
    stim_t s[$];
    logic [6:0] e[$];
    logic [6:0] got;
    logic [6:0] want;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0)); e.push_back(E_FRZ);
    end
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1)); e.push_back(E_JMP);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(E_IDLE);
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got = sample();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL hold_jump step %0d: got %b want %b", i, got, want);
      end
    end
    n_cmp++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd3) begin
      n_bad++; $display("FAIL hold_jump cnt: got flush %0d stall %0d want 1 3", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_timeout();
    stim_t s[$];
    stim_t s2[$];
    logic [6:0] e[$];
    logic [6:0] e2[$];
    logic [6:0] got;
    logic [6:0] want;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(E_FRZ);
    end
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(E_HLT);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1)); e.push_back(E_HLT);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(E_HLT);
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got = sample();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL timeout step %0d: got %b want %b", i, got, want);
      end
    end
    n_cmp++;
    if (stall_cnt !== 4'd7 || flush_cnt !== 4'd0) begin
      n_bad++; $display("FAIL timeout cnt: got stall %0d flush %0d want 7 0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    got = sample();
    n_cmp++;
    if (bus_err !== 1'b0 || stall_cnt !== 4'd0 || {got[6:2], got[0]} !== 6'b00110_0) begin
      n_bad++; $display("FAIL timeout async_reset: got ctrl %b stall %0d want 00110x0 0", got, stall_cnt);
    end
    #1 reset = 1'b1;
    s2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)); e2.push_back(E_FRZ);
    s2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1)); e2.push_back(E_IDLE);
    s2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e2.push_back(E_IDLE);
    foreach (s2[i]) begin
      @(posedge clk); #1;
      apply(s2[i]);
      exp_q.push_back(e2[i]);
      @(negedge clk);
      got = sample();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL timeout post_reset step %0d: got %b want %b", i, got, want);
      end
    end
  endtask

  task automatic test_saturation();
    logic [6:0] got;
    logic [6:0] want;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      if (i < 20) begin
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); exp_q.push_back(E_FM);
      end else begin
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); exp_q.push_back(E_IDLE);
      end
      @(negedge clk);
      got = sample();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL sat_stall step %0d: got %b want %b", i, got, want);
      end
      if (i == 10) begin
        n_cmp++;
        if (stall_cnt !== 4'd10) begin
          n_bad++; $display("FAIL sat_stall mid: got %0d want 10", stall_cnt);
        end
      end
    end
    n_cmp++;
    if (stall_cnt !== 4'd15) begin
      n_bad++; $display("FAIL sat_stall final: got %0d want 15", stall_cnt);
    end
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      if (i < 20) begin
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0)); exp_q.push_back(E_JMP);
      end else begin
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); exp_q.push_back(E_IDLE);
      end
      @(negedge clk);
      got = sample();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL sat_flush step %0d: got %b want %b", i, got, want);
      end
    end
    n_cmp++;
    if (flush_cnt !== 4'd15 || stall_cnt !== 4'd15) begin
      n_bad++; $display("FAIL sat_flush final: got flush %0d stall %0d want 15 15", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    logic [6:0] e[$];
    logic [6:0] got;
    logic [6:0] want;
    do_reset();
    s.push_back(mk(6, 1, 0, 0, 6, 1, 0, 1, 0, 0)); e.push_back(E_LU);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0)); e.push_back(E_JMP);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(E_FM);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0)); e.push_back(E_FRZ);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); e.push_back(E_FM);
    s.push_back(mk(0, 0, 8, 1, 8, 1, 0, 1, 0, 0)); e.push_back(E_LU);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(E_IDLE);
    foreach (s[i]) begin
      @(posedge clk); #1;
      apply(s[i]);
      exp_q.push_back(e[i]);
      @(negedge clk);
      got = sample();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL back_to_back step %0d: got %b want %b", i, got, want);
      end
    end
    n_cmp++;
    if (stall_cnt !== 4'd5 || flush_cnt !== 4'd1) begin
      n_bad++; $display("FAIL back_to_back cnt: got stall %0d flush %0d want 5 1", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    test_reset();
    test_load_use();
    test_x0_unused();
    test_jump_fetch_miss();
    test_hold_jump();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
